scr1_pipe_mprf_sb: RTL and testbench

Parametrised multi-port integer register file with an integrated pending-write scoreboard, for multi-issue and out-of-order-writeback pipelines. Provides NRD asynchronous read ports, NWR write ports with fixed priority, and a reservation port that marks destination registers busy at issue until writeback clears them. A pending-register counter exposes scoreboard occupancy for drain/flush control.

---
 rtl/scr1_mprf_pkg.sv | 36 +++
 rtl/scr1_mprf_wsel.sv | 41 ++++
 rtl/scr1_pipe_mprf_sb.sv | 110 +++++++++++
 tb/tb_scr1_pipe_mprf_sb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_mprf_pkg.sv
// Shared constants, port payload types and the highest-index write-match helper
// for the multi-port register file with pending-write scoreboard.
package scr1_mprf_pkg;

    localparam int unsigned MPRF_XLEN    = 32;
    localparam int unsigned MPRF_DEPTH   = 32;
    localparam int unsigned MPRF_NRD     = 2;
    localparam int unsigned MPRF_NWR     = 2;
    localparam int unsigned MPRF_AW      = $clog2(MPRF_DEPTH);
    localparam int unsigned MPRF_NWR_MAX = 3;
    localparam int unsigned MPRF_PIW     = 2;

    typedef logic [MPRF_NRD-1:0][MPRF_AW-1:0]   mprf_rd_addr_t;
    typedef logic [MPRF_NRD-1:0][MPRF_XLEN-1:0] mprf_rd_data_t;
    typedef logic [MPRF_NWR-1:0][MPRF_AW-1:0]   mprf_wr_addr_t;
    typedef logic [MPRF_NWR-1:0][MPRF_XLEN-1:0] mprf_wr_data_t;

    typedef struct packed {
        logic                vld;
        logic [MPRF_PIW-1:0] idx;
    } mprf_wsel_t;

    // Later ports override earlier ones, so the highest matching index wins
    function automatic mprf_wsel_t mprf_hi_match(input logic [MPRF_NWR_MAX-1:0] hit);
        mprf_wsel_t res;
        res = '0;
        for (int unsigned p = 0; p < MPRF_NWR_MAX; p++) begin
            if (hit[p]) begin
                res.vld = 1'b1;
                res.idx = MPRF_PIW'(p);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/scr1_mprf_wsel.sv
// Per-register priority write decoder: collapses NWR write ports into one
// write enable and one selected data word per architectural register.
module scr1_mprf_wsel
    import scr1_mprf_pkg::*;
#(
    parameter int unsigned XLEN  = MPRF_XLEN,
    parameter int unsigned DEPTH = MPRF_DEPTH,
    parameter int unsigned NWR   = MPRF_NWR,
    parameter int unsigned AW    = $clog2(DEPTH)
)(
    input  logic [NWR-1:0]              wr_req_i,
    input  logic [NWR-1:0][AW-1:0]      wr_addr_i,
    input  logic [NWR-1:0][XLEN-1:0]    wr_data_i,
    output logic [DEPTH-1:0]            we_o,
    output logic [DEPTH-1:0][XLEN-1:0]  wdata_o
);

    logic [MPRF_NWR_MAX-1:0] w_hit;
    mprf_wsel_t              w_sel;

    always_comb begin
        we_o    = '0;
        wdata_o = '0;
        w_hit   = '0;
        w_sel   = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            w_hit = '0;
            for (int unsigned p = 0; p < NWR; p++) begin
                w_hit[p] = wr_req_i[p] && (wr_addr_i[p] == AW'(r));
            end
            w_sel    = mprf_hi_match(w_hit);
            we_o[r]  = w_sel.vld;
            for (int unsigned p = 0; p < NWR; p++) begin
                if (w_sel.idx == MPRF_PIW'(p)) begin
                    wdata_o[r] = wr_data_i[p];
                end
            end
        end
    end

endmodule

// File: rtl/scr1_pipe_mprf_sb.sv
// Multi-port integer register file with pending-write scoreboard.
// Optional write-to-read bypass enabled by defining SCR1_MPRF_BYPASS_EN.
module scr1_pipe_mprf_sb
    import scr1_mprf_pkg::*;
#(
    parameter int unsigned XLEN     = MPRF_XLEN,
    parameter int unsigned DEPTH    = MPRF_DEPTH,
    parameter int unsigned NRD      = MPRF_NRD,
    parameter int unsigned NWR      = MPRF_NWR,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned AW       = $clog2(DEPTH)
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NRD-1:0][AW-1:0]     rd_addr_i,
    output logic [NRD-1:0][XLEN-1:0]   rd_data_o,
    output logic [NRD-1:0]             rd_busy_o,
    input  logic [NWR-1:0]             wr_req_i,
    input  logic [NWR-1:0][AW-1:0]     wr_addr_i,
    input  logic [NWR-1:0][XLEN-1:0]   wr_data_i,
    input  logic                       rsv_req_i,
    input  logic [AW-1:0]              rsv_addr_i,
    output logic                       rsv_stall_o,
    output logic [AW:0]                pend_cnt_o
);

    localparam int unsigned CW = AW + 1;
    // Register 0 drops out of every update path when it is hardwired
    localparam logic [DEPTH-1:0] IMPL_MASK = {{(DEPTH-1){1'b1}}, ~ZERO_REG};

    logic [DEPTH-1:0][XLEN-1:0] r_regs;
    logic [DEPTH-1:0]           r_busy;
    logic [CW-1:0]              r_pend_cnt;

    logic [DEPTH-1:0]           w_we_raw;
    logic [DEPTH-1:0]           w_we;
    logic [DEPTH-1:0][XLEN-1:0] w_wdata;
    logic [DEPTH-1:0]           w_rsv_set;
    logic [DEPTH-1:0]           w_busy_nxt;
    logic [CW-1:0]              w_pend_nxt;

    scr1_mprf_wsel #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .NWR   (NWR),
        .AW    (AW)
    ) u_wsel (
        .wr_req_i  (wr_req_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .we_o      (w_we_raw),
        .wdata_o   (w_wdata)
    );

    assign w_we = w_we_raw & IMPL_MASK;

    // A same-cycle clearing write hands ownership straight to the new producer
    assign rsv_stall_o = rsv_req_i & r_busy[rsv_addr_i] & ~w_we[rsv_addr_i];

    always_comb begin
        w_rsv_set = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            w_rsv_set[r] = rsv_req_i && !rsv_stall_o && (rsv_addr_i == AW'(r)) && IMPL_MASK[r];
        end
    end

    assign w_busy_nxt = ((r_busy & ~w_we) | w_rsv_set) & IMPL_MASK;

    // Occupancy is the population of next-cycle busy bits: net of sets and clears
    always_comb begin
        w_pend_nxt = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            w_pend_nxt = w_pend_nxt + CW'(w_busy_nxt[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs     <= '0;
            r_busy     <= '0;
            r_pend_cnt <= '0;
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (w_we[r]) begin
                    r_regs[r] <= w_wdata[r];
                end
            end
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= w_pend_nxt;
        end
    end

    assign pend_cnt_o = r_pend_cnt;

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_data_o[i] = r_regs[rd_addr_i[i]];
            rd_busy_o[i] = r_busy[rd_addr_i[i]];
`ifdef SCR1_MPRF_BYPASS_EN
            if (w_we[rd_addr_i[i]]) begin
                rd_data_o[i] = w_wdata[rd_addr_i[i]];
                rd_busy_o[i] = w_rsv_set[rd_addr_i[i]];
            end
`endif
        end
    end

endmodule

// File: tb/tb_scr1_pipe_mprf_sb.sv
// Self-checking bench for scr1_pipe_mprf_sb: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_scr1_pipe_mprf_sb;
    import scr1_mprf_pkg::*;

`ifdef SCR1_MPRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    mprf_rd_addr_t rd_addr;
    mprf_rd_data_t rd_data;
    logic [1:0]    rd_busy;
    logic [1:0]    wr_req;
    mprf_wr_addr_t wr_addr;
    mprf_wr_data_t wr_data;
    logic          rsv_req;
    logic [4:0]    rsv_addr;
    logic          rsv_stall;
    logic [5:0]    pend_cnt;

    int tests  = 0;
    int failed = 0;

    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    scr1_pipe_mprf_sb #(
        .XLEN(32), .DEPTH(32), .NRD(2), .NWR(2), .ZERO_REG(1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_busy_o   (rd_busy),
        .wr_req_i    (wr_req),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rsv_req_i   (rsv_req),
        .rsv_addr_i  (rsv_addr),
        .rsv_stall_o (rsv_stall),
        .pend_cnt_o  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wreq;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        rsv;
        logic [4:0]  ra;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        eb0;
        logic        eb1;
        logic        es;
        logic [5:0]  ec;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic [1:0] wreq, input logic [4:0] wa0, input logic [31:0] wd0,
        input logic [4:0] wa1, input logic [31:0] wd1, input logic rsv, input logic [4:0] ra,
        input logic [4:0] rd0, input logic [4:0] rd1, input logic [31:0] ed0, input logic [31:0] ed1,
        input logic eb0, input logic eb1, input logic es, input logic [5:0] ec);
        vec_t v;
        v.wreq = wreq; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.rsv = rsv; v.ra = ra; v.rd0 = rd0; v.rd1 = rd1;
        v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1; v.es = es; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_req   = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_req  = 1'b0;
        rsv_addr = '0;
        rd_addr  = '0;
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    // One randomized cycle: predict from architectural rules, compare, then retire
    task automatic rand_step(input int n);
        bit          wv [32];
        logic [31:0] wd [32];
        bit          exp_s;
        bit          accept;
        logic [31:0] exp_d;
        bit          exp_b;
        int          exp_c;
        int          a;
        @(negedge clk);
        wr_req   = 2'($urandom_range(0, 3));
        rsv_req  = 1'($urandom_range(0, 1));
        rsv_addr = pick_addr();
        for (int p = 0; p < 2; p++) begin
            wr_addr[p] = pick_addr();
            wr_data[p] = $urandom();
            rd_addr[p] = pick_addr();
        end
        for (int k = 0; k < 32; k++) begin
            wv[k] = 1'b0;
            wd[k] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            if (wr_req[p] && wr_addr[p] != 0) begin
                wv[wr_addr[p]] = 1'b1;
                wd[wr_addr[p]] = wr_data[p];
            end
        end
        exp_s  = rsv_req && m_busy[rsv_addr] && !wv[rsv_addr];
        accept = rsv_req && !exp_s && rsv_addr != 0;
        #1;
        chk($sformatf("rnd%0d stall", n), 32'(rsv_stall), 32'(exp_s));
        for (int i = 0; i < 2; i++) begin
            a     = int'(rd_addr[i]);
            exp_d = m_reg[a];
            exp_b = m_busy[a];
            if (BYP && wv[a]) begin
                exp_d = wd[a];
                exp_b = accept && (int'(rsv_addr) == a);
            end
            chk($sformatf("rnd%0d rd_data%0d", n, i), rd_data[i], exp_d);
            chk($sformatf("rnd%0d rd_busy%0d", n, i), 32'(rd_busy[i]), 32'(exp_b));
        end
        @(posedge clk);
        for (int k = 0; k < 32; k++) begin
            if (wv[k]) begin
                m_reg[k]  = wd[k];
                m_busy[k] = 1'b0;
            end
        end
        if (accept) m_busy[rsv_addr] = 1'b1;
        #1;
        exp_c = 0;
        for (int k = 0; k < 32; k++) exp_c += int'(m_busy[k]);
        chk($sformatf("rnd%0d pend_cnt", n), 32'(pend_cnt), 32'(exp_c));
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state across all addresses
        for (int a = 0; a < 32; a += 2) begin
            rd_addr[0] = 5'(a);
            rd_addr[1] = 5'(a + 1);
            #1;
            chk($sformatf("reset rd_data x%0d", a), rd_data[0], 32'h0);
            chk($sformatf("reset rd_data x%0d", a + 1), rd_data[1], 32'h0);
            chk($sformatf("reset rd_busy x%0d/x%0d", a, a + 1), 32'(rd_busy), 32'h0);
        end
        chk("reset pend_cnt", 32'(pend_cnt), 32'h0);
        chk("reset stall", 32'(rsv_stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: read outputs checked before the edge, pend_cnt after it
        tv.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 31, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(2'b11, 5, 32'h1111, 5, 32'h2222, 0, 0, 5, 1, BYP ? 32'h2222 : 32'h0, 0, 0, 0, 0, 0));
        tv.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 5, 5, 32'h2222, 32'h2222, 0, 0, 0, 0));
        tv.push_back(mk(2'b00, 0, 0, 0, 0, 1, 7, 7, 5, 0, 32'h2222, 0, 0, 0, 1));
        tv.push_back(mk(2'b00, 0, 0, 0, 0, 1, 7, 7, 5, 0, 32'h2222, 1, 0, 1, 1));
        tv.push_back(mk(2'b01, 7, 32'hA5A5, 0, 0, 0, 0, 7, 5, BYP ? 32'hA5A5 : 32'h0, 32'h2222, !BYP, 0, 0, 0));
        tv.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 3, 32'hA5A5, 0, 0, 0, 0, 0));
        tv.push_back(mk(2'b10, 0, 0, 3, 32'h55, 1, 3, 3, 7, BYP ? 32'h55 : 32'h0, 32'hA5A5, BYP, 0, 0, 1));
        tv.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 3, 0, 32'h55, 0, 1, 0, 0, 1));
        tv.push_back(mk(2'b01, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 3, 0, 32'h55, 0, 1, 0, 1));
        tv.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 0, 32'h55, 0, 1, 0, 1));
        tv.push_back(mk(2'b10, 0, 0, 9, 32'h1234, 0, 0, 9, 3, BYP ? 32'h1234 : 32'h0, 32'h55, 0, 1, 0, 1));
        tv.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 32'h1234, 32'h1234, 0, 0, 0, 1));
        tv.push_back(mk(2'b01, 3, 32'h66, 0, 0, 1, 3, 3, 9, BYP ? 32'h66 : 32'h55, 32'h1234, 1, 0, 0, 1));
        tv.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 3, 9, 32'h66, 32'h1234, 1, 0, 0, 1));
        tv.push_back(mk(2'b00, 0, 0, 0, 0, 1, 3, 3, 9, 32'h66, 32'h1234, 1, 0, 1, 1));

        foreach (tv[i]) begin
            @(negedge clk);
            wr_req     = tv[i].wreq;
            wr_addr[0] = tv[i].wa0;
            wr_data[0] = tv[i].wd0;
            wr_addr[1] = tv[i].wa1;
            wr_data[1] = tv[i].wd1;
            rsv_req    = tv[i].rsv;
            rsv_addr   = tv[i].ra;
            rd_addr[0] = tv[i].rd0;
            rd_addr[1] = tv[i].rd1;
            #1;
            chk($sformatf("tv%0d rd_data0", i), rd_data[0], tv[i].ed0);
            chk($sformatf("tv%0d rd_data1", i), rd_data[1], tv[i].ed1);
            chk($sformatf("tv%0d rd_busy0", i), 32'(rd_busy[0]), 32'(tv[i].eb0));
            chk($sformatf("tv%0d rd_busy1", i), 32'(rd_busy[1]), 32'(tv[i].eb1));
            chk($sformatf("tv%0d stall", i), 32'(rsv_stall), 32'(tv[i].es));
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d pend_cnt", i), 32'(pend_cnt), 32'(tv[i].ec));
        end

        // Fill the scoreboard: x3 already busy, reserve every other implemented register
        for (int a = 1; a < 32; a++) begin
            if (a == 3) continue;
            @(negedge clk);
            idle_inputs();
            rsv_req  = 1'b1;
            rsv_addr = 5'(a);
        end
        @(negedge clk);
        idle_inputs();
        chk("fill pend_cnt max", 32'(pend_cnt), 32'd31);
        rsv_req  = 1'b1;
        rsv_addr = 5'd0;
        #1;
        chk("fill rsv x0 stall", 32'(rsv_stall), 32'h0);
        @(posedge clk);
        #1;
        chk("fill rsv x0 pend_cnt", 32'(pend_cnt), 32'd31);

        // Two distinct clearing writes in one cycle retire two entries
        @(negedge clk);
        idle_inputs();
        wr_req     = 2'b11;
        wr_addr[0] = 5'd4;
        wr_addr[1] = 5'd5;
        wr_data[0] = 32'hAAAA;
        wr_data[1] = 32'hBBBB;
        @(posedge clk);
        #1;
        chk("dual clear pend_cnt", 32'(pend_cnt), 32'd29);

        // Asynchronous reset mid-operation drops everything without a clock edge
        @(negedge clk);
        idle_inputs();
        rd_addr[0] = 5'd4;
        rd_addr[1] = 5'd3;
        rst_n      = 1'b0;
        #1;
        chk("midrst pend_cnt", 32'(pend_cnt), 32'h0);
        chk("midrst rd_data0", rd_data[0], 32'h0);
        chk("midrst rd_busy", 32'(rd_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 32; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 1'b0;
        end
        for (int n = 0; n < 1500; n++) rand_step(n);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
